// File: rtl/layer1_neuron_mac_if.sv
// Bus bundle for the layer-1 MAC: activation input stream, weight ROM port and
// result output stream. The engine uses the slave view, its environment the master view.
interface layer1_neuron_mac_if #(
  parameter int ACT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [ACT_W-1:0] in_data;
  logic [7:0]       weight_addr;
  logic [19:0]      weight_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACT_W-1:0] out_data;
  logic [7:0]       out_idx;
  logic             out_last;

  modport slave (
    input  in_valid, in_data, weight_data, out_ready,
    output in_ready, weight_addr, out_valid, out_data, out_idx, out_last
  );

  modport master (
    output in_valid, in_data, weight_data, out_ready,
    input  in_ready, weight_addr, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/layer1_neuron_mac.sv
// Layer-1 dot-product engine: buffers one activation vector, then runs one MAC per
// cycle per neuron against the weight ROM. Optional ReLU on results: `define LAYER1_RELU_EN.
module layer1_neuron_mac #(
  parameter int NUM_INPUTS  = 16,
  parameter int NUM_NEURONS = 16,
  parameter int ACT_W       = 16,
  parameter int ACC_W       = 40
) (
  input logic                clk,
  input logic                rst,
  layer1_neuron_mac_if.slave bus
);
  localparam int PROD_W = 20 + ACT_W;
  localparam int IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  localparam logic [7:0] LAST_I = 8'(NUM_INPUTS - 1);
  localparam logic [7:0] LAST_N = 8'(NUM_NEURONS - 1);

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** 18);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(2 ** (ACT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;
  localparam logic [ACT_W-1:0]        RES_MAX  = {1'b0, {(ACT_W-1){1'b1}}};
  localparam logic [ACT_W-1:0]        RES_MIN  = {1'b1, {(ACT_W-1){1'b0}}};

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  state_t                  state;
  logic [ACT_W-1:0]        act_buf [NUM_INPUTS];
  logic [7:0]              ld_cnt;
  logic [7:0]              i_cnt;
  logic [7:0]              n_cnt;
  logic signed [ACC_W-1:0] acc;

  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [ACT_W-1:0]        out_data_q;
  logic [7:0]              out_idx_q;
  logic                    out_last_q;

  logic signed [19:0]       weight_s;
  logic signed [ACT_W-1:0]  act_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [ACC_W-1:0]  shifted;
  logic [ACT_W-1:0]         result;
  logic                     in_fire;

  // n_cnt/i_cnt are only touched by the compute path, so the address naturally
  // holds its last value through OUTPUT and LOAD.
  assign bus.weight_addr = n_cnt * 8'(NUM_INPUTS) + i_cnt;
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_idx     = out_idx_q;
  assign bus.out_last    = out_last_q;

  assign in_fire = (state == LOAD) && bus.in_valid && in_ready_q;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    weight_s = '0;
    act_s    = '0;
    prod     = '0;
    acc_nxt  = '0;
    rnd      = '0;
    shifted  = '0;
    result   = '0;

    // Sign-magnitude to two's complement; negative zero falls out as 0.
    if (bus.weight_data[19]) weight_s = -$signed({1'b0, bus.weight_data[18:0]});
    else                     weight_s =  $signed({1'b0, bus.weight_data[18:0]});

    act_s   = $signed(act_buf[i_cnt[IDX_W-1:0]]);
    prod    = weight_s * act_s;
    acc_nxt = acc + ACC_W'(prod);

    rnd     = acc_nxt + RND_HALF;
    shifted = rnd >>> 19;
    if (shifted > SAT_MAX)      result = RES_MAX;
    else if (shifted < SAT_MIN) result = RES_MIN;
    else                        result = shifted[ACT_W-1:0];

`ifdef LAYER1_RELU_EN
    if (result[ACT_W-1]) result = '0;
`else
    result = result;
`endif
  end

  // NOTE: the activation buffer has no reset; it is always fully rewritten before being read.
  always_ff @(posedge clk) begin
    if (in_fire) act_buf[ld_cnt[IDX_W-1:0]] <= bus.in_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      ld_cnt      <= '0;
      i_cnt       <= '0;
      n_cnt       <= '0;
      acc         <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (in_fire) begin
            if (ld_cnt == LAST_I) begin
              ld_cnt     <= '0;
              in_ready_q <= 1'b0;
              n_cnt      <= '0;
              i_cnt      <= '0;
              acc        <= '0;
              state      <= COMPUTE;
            end else begin
              ld_cnt <= ld_cnt + 8'd1;
            end
          end
        end

        COMPUTE: begin
          acc <= acc_nxt;
          if (i_cnt == LAST_I) begin
            // The final term is folded in combinationally so the result lands one cycle later.
            out_valid_q <= 1'b1;
            out_data_q  <= result;
            out_idx_q   <= n_cnt;
            out_last_q  <= (n_cnt == LAST_N);
            state       <= OUTPUT;
          end else begin
            i_cnt <= i_cnt + 8'd1;
          end
        end

        OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              in_ready_q <= 1'b1;
              state      <= LOAD;
            end else begin
              n_cnt <= n_cnt + 8'd1;
              i_cnt <= '0;
              acc   <= '0;
              state <= COMPUTE;
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_layer1_neuron_mac.sv
// Directed bench for layer1_neuron_mac: a 4-input/2-neuron instance and a
// 1-input/1-neuron instance, each fed by a constant-word ROM set per test.
module tb_layer1_neuron_mac;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [19:0] rom4;
  logic [19:0] rom1;

  layer1_neuron_mac_if #(.ACT_W(16)) bus4 ();
  layer1_neuron_mac_if #(.ACT_W(16)) bus1 ();

  assign bus4.weight_data = rom4;
  assign bus1.weight_data = rom1;

  layer1_neuron_mac #(.NUM_INPUTS(4), .NUM_NEURONS(2), .ACT_W(16), .ACC_W(40)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  layer1_neuron_mac #(.NUM_INPUTS(1), .NUM_NEURONS(1), .ACT_W(16), .ACC_W(40)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // Expected value for a negative result, depending on whether ReLU is built in.
  function automatic logic [15:0] neg_res(input logic [15:0] v);
`ifdef LAYER1_RELU_EN
    return 16'h0000;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] a2, input logic [15:0] a3);
    logic [15:0] a [4];
    a = '{a0, a1, a2, a3};
    for (int k = 0; k < 4; k++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = a[k];
      total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL load4_in_ready[%0d]: got %b exp 1", k, bus4.in_ready); end
      tick();
    end
    bus4.in_valid = 1'b0;
    total++; if (bus4.in_ready !== 1'b0) begin bad++; $display("FAIL load4_ready_drop: got %b exp 0", bus4.in_ready); end
  endtask

  // Entered on the first COMPUTE cycle of neuron idx; leaves after its handshake.
  task automatic run_neuron4(input logic [15:0] exp_data, input logic [7:0] idx, input int hold);
    logic [7:0] base;
    logic       exp_last;
    base     = 8'(idx * 8'd4);
    exp_last = (idx == 8'd1);
    for (int k = 0; k < 4; k++) begin
      if (hold > 0) begin bus4.in_valid = 1'b1; bus4.in_data = 16'h7FFF; end
      total++; if (bus4.weight_addr !== base + 8'(k)) begin bad++; $display("FAIL addr n%0d i%0d: got %0d exp %0d", idx, k, bus4.weight_addr, base + 8'(k)); end
      total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL early_valid n%0d i%0d: got %b exp 0", idx, k, bus4.out_valid); end
      total++; if (bus4.in_ready !== 1'b0) begin bad++; $display("FAIL compute_in_ready n%0d i%0d: got %b exp 0", idx, k, bus4.in_ready); end
      tick();
    end
    bus4.in_valid = 1'b0;
    total++; if (bus4.out_valid !== 1'b1) begin bad++; $display("FAIL valid n%0d: got %b exp 1", idx, bus4.out_valid); end
    total++; if (bus4.out_data !== exp_data) begin bad++; $display("FAIL data n%0d: got %h exp %h", idx, bus4.out_data, exp_data); end
    total++; if (bus4.out_idx !== idx) begin bad++; $display("FAIL idx n%0d: got %0d exp %0d", idx, bus4.out_idx, idx); end
    total++; if (bus4.out_last !== exp_last) begin bad++; $display("FAIL last n%0d: got %b exp %b", idx, bus4.out_last, exp_last); end

    bus4.out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = 16'h7FFF;
      tick();
      total++; if (bus4.out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid c%0d: got %b exp 1", h, bus4.out_valid); end
      total++; if (bus4.out_data !== exp_data) begin bad++; $display("FAIL hold_data c%0d: got %h exp %h", h, bus4.out_data, exp_data); end
      total++; if (bus4.out_idx !== idx) begin bad++; $display("FAIL hold_idx c%0d: got %0d exp %0d", h, bus4.out_idx, idx); end
      total++; if (bus4.weight_addr !== base + 8'd3) begin bad++; $display("FAIL hold_addr c%0d: got %0d exp %0d", h, bus4.weight_addr, base + 8'd3); end
      total++; if (bus4.in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready c%0d: got %b exp 0", h, bus4.in_ready); end
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    tick();
    total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL valid_clear n%0d: got %b exp 0", idx, bus4.out_valid); end
    if (exp_last) begin
      total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL back_to_load: in_ready got %b exp 1", bus4.in_ready); end
    end else begin
      total++; if (bus4.weight_addr !== base + 8'd4) begin bad++; $display("FAIL next_start_addr: got %0d exp %0d", bus4.weight_addr, base + 8'd4); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b exp 1", bus4.in_ready); end
    total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b exp 0", bus4.out_valid); end
    total++; if (bus4.out_data !== 16'h0000) begin bad++; $display("FAIL rst_out_data: got %h exp 0000", bus4.out_data); end
    total++; if (bus4.out_idx !== 8'd0) begin bad++; $display("FAIL rst_out_idx: got %0d exp 0", bus4.out_idx); end
    total++; if (bus4.out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last: got %b exp 0", bus4.out_last); end
    total++; if (bus4.weight_addr !== 8'd0) begin bad++; $display("FAIL rst_addr: got %0d exp 0", bus4.weight_addr); end
    total++; if (bus1.in_ready !== 1'b1) begin bad++; $display("FAIL rst1_in_ready: got %b exp 1", bus1.in_ready); end
    total++; if (bus1.out_valid !== 1'b0) begin bad++; $display("FAIL rst1_out_valid: got %b exp 0", bus1.out_valid); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    rom4 = 20'h40000;
    load4(16'h2000, 16'h2000, 16'h2000, 16'h2000);
    run_neuron4(16'h4000, 8'd0, 0);
    run_neuron4(16'h4000, 8'd1, 0);
  endtask

  task automatic test_negative();
    rom4 = 20'hC0000;
    load4(16'h2000, 16'h2000, 16'h2000, 16'h2000);
    run_neuron4(neg_res(16'hC000), 8'd0, 0);
    run_neuron4(neg_res(16'hC000), 8'd1, 0);
  endtask

  task automatic test_saturation();
    rom4 = 20'h7FFFF;
    load4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_neuron4(16'h7FFF, 8'd0, 0);
    run_neuron4(16'h7FFF, 8'd1, 0);
    rom4 = 20'hFFFFF;
    load4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_neuron4(neg_res(16'h8000), 8'd0, 0);
    run_neuron4(neg_res(16'h8000), 8'd1, 0);
  endtask

  task automatic test_single_input();
    logic [15:0] acts [4];
    logic [19:0] ws   [4];
    logic [15:0] exps [4];
    acts = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h4000};
    ws   = '{20'h40000, 20'h40000, 20'h80000, 20'hC0000};
    exps = '{16'h0001, 16'h0000, 16'h0000, neg_res(16'hE000)};
    for (int t = 0; t < 4; t++) begin
      rom1          = ws[t];
      bus1.in_valid = 1'b1;
      bus1.in_data  = acts[t];
      total++; if (bus1.in_ready !== 1'b1) begin bad++; $display("FAIL n1_in_ready t%0d: got %b exp 1", t, bus1.in_ready); end
      tick();
      bus1.in_valid = 1'b0;
      total++; if (bus1.weight_addr !== 8'd0) begin bad++; $display("FAIL n1_addr t%0d: got %0d exp 0", t, bus1.weight_addr); end
      total++; if (bus1.out_valid !== 1'b0) begin bad++; $display("FAIL n1_early_valid t%0d: got %b exp 0", t, bus1.out_valid); end
      tick();
      total++; if (bus1.out_valid !== 1'b1) begin bad++; $display("FAIL n1_valid t%0d: got %b exp 1", t, bus1.out_valid); end
      total++; if (bus1.out_data !== exps[t]) begin bad++; $display("FAIL n1_data t%0d: got %h exp %h", t, bus1.out_data, exps[t]); end
      total++; if (bus1.out_last !== 1'b1) begin bad++; $display("FAIL n1_last t%0d: got %b exp 1", t, bus1.out_last); end
      total++; if (bus1.out_idx !== 8'd0) begin bad++; $display("FAIL n1_idx t%0d: got %0d exp 0", t, bus1.out_idx); end
      tick();
      total++; if (bus1.out_valid !== 1'b0) begin bad++; $display("FAIL n1_valid_clear t%0d: got %b exp 0", t, bus1.out_valid); end
      total++; if (bus1.in_ready !== 1'b1) begin bad++; $display("FAIL n1_reload t%0d: got %b exp 1", t, bus1.in_ready); end
    end
  endtask

  task automatic test_back_to_back_hold();
    rom4 = 20'h40000;
    load4(16'h2000, 16'h2000, 16'h2000, 16'h2000);
    run_neuron4(16'h4000, 8'd0, 5);
    run_neuron4(16'h4000, 8'd1, 0);
  endtask

  task automatic test_reset_mid();
    rom4 = 20'h40000;
    load4(16'h2000, 16'h2000, 16'h2000, 16'h2000);
    run_neuron4(16'h4000, 8'd0, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b exp 1", bus4.in_ready); end
    total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b exp 0", bus4.out_valid); end
    total++; if (bus4.out_idx !== 8'd0) begin bad++; $display("FAIL midrst_out_idx: got %0d exp 0", bus4.out_idx); end
    total++; if (bus4.weight_addr !== 8'd0) begin bad++; $display("FAIL midrst_addr: got %0d exp 0", bus4.weight_addr); end
    for (int c = 0; c < 6; c++) begin
      tick();
      total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_idle_valid c%0d: got %b exp 0", c, bus4.out_valid); end
    end
    load4(16'h1000, 16'h2000, 16'h3000, 16'h4000);
    run_neuron4(16'h5000, 8'd0, 0);
    run_neuron4(16'h5000, 8'd1, 0);
  endtask

  initial begin
    rst            = 1'b1;
    rom4           = 20'h00000;
    rom1           = 20'h00000;
    bus4.in_valid  = 1'b0;
    bus4.in_data   = 16'h0000;
    bus4.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = 16'h0000;
    bus1.out_ready = 1'b1;

    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_single_input();
    test_back_to_back_hold();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
